// File: rtl/pll_dyn_pkg.sv
// Shared types and divider code table for the PLLVR dynamic-divider controller.
package pll_dyn_pkg;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_WAIT_LOCK,
    ST_QUALIFY,
    ST_RUN,
    ST_FAIL
  } pll_state_t;

  localparam int unsigned CODE_W    = 6;
  localparam int unsigned TAB_MODES = 4;

  // One set of dynamic divider port codes (64 - divider, ODSEL per PLLVR encoding).
  typedef struct packed {
    logic [CODE_W-1:0] idsel;
    logic [CODE_W-1:0] fbdsel;
    logic [CODE_W-1:0] odsel;
  } div_codes_t;

  // Entry i sits at bits [i*6 +: 6]; entry 0 is 27 MHz -> 126 MHz (IDIV 3, FBDIV 14, ODIV 4).
  // 1: 74.25 MHz (4/11/8), 2: 148.5 MHz (2/11/4), 3: 135 MHz (1/5/4).
  localparam logic [TAB_MODES*CODE_W-1:0] IDSEL_TAB  = {6'd63, 6'd62, 6'd60, 6'd61};
  localparam logic [TAB_MODES*CODE_W-1:0] FBDSEL_TAB = {6'd59, 6'd53, 6'd53, 6'd50};
  localparam logic [TAB_MODES*CODE_W-1:0] ODSEL_TAB  = {6'd62, 6'd62, 6'd60, 6'd62};

  // Table lookup; indices beyond the table fall back to the 126 MHz entry.
  function automatic div_codes_t div_lookup(input int unsigned idx);
    div_codes_t  c;
    int unsigned i;
    i        = (idx < TAB_MODES) ? idx : 0;
    c.idsel  = CODE_W'(IDSEL_TAB >> (CODE_W * i));
    c.fbdsel = CODE_W'(FBDSEL_TAB >> (CODE_W * i));
    c.odsel  = CODE_W'(ODSEL_TAB >> (CODE_W * i));
    return c;
  endfunction

endpackage

// File: rtl/pll_dyn_if.sv
// Mode request handshake between the video-mode selector and the PLL controller.
interface pll_dyn_if #(
  parameter int unsigned MODE_W = 2
);
  logic [MODE_W-1:0] mode_req;
  logic              mode_req_valid;
  logic              mode_req_ready;
  logic              bad_mode;

  modport master (
    output mode_req,
    output mode_req_valid,
    input  mode_req_ready,
    input  bad_mode
  );

  modport slave (
    input  mode_req,
    input  mode_req_valid,
    output mode_req_ready,
    output bad_mode
  );
endinterface

// File: rtl/pll_dyn_ctrl_lock_sync.sv
// Two-flop synchroniser bringing the raw PLL lock into the clkin domain.
module lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  // Double-register the asynchronous lock; both stages clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pll_dyn_ctrl.sv
// PLLVR dynamic-divider controller: reset pulse, lock acquisition/qualification,
// lock-loss recovery, bounded retry and mode switching from the divider table.
module pll_dyn_ctrl
  import pll_dyn_pkg::*;
#(
  parameter int unsigned NUM_MODES    = 4,
  parameter int unsigned MODE_W       = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
  parameter int unsigned DEFAULT_MODE = 0,
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic              clkin,
  input  logic              rst_n,
  pll_dyn_if.slave          bus,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic [5:0]        pll_idsel,
  output logic [5:0]        pll_fbdsel,
  output logic [5:0]        pll_odsel,
  output logic [MODE_W-1:0] mode_cur,
  output logic              locked,
  output logic              fail,
  output logic [1:0]        retry_cnt
);

  localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned TMO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int unsigned STB_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;

  localparam logic [RST_W-1:0]  RST_LAST    = RST_W'(RESET_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0]  STB_LAST    = STB_W'(LOCK_STABLE - 1);
  localparam logic [MODE_W-1:0] MODE_RESET  = MODE_W'(DEFAULT_MODE);
  localparam div_codes_t        DIV_DEFAULT = div_lookup(DEFAULT_MODE);

  pll_state_t        state_q, state_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [STB_W-1:0]  stb_cnt_q, stb_cnt_d;
  logic [1:0]        retry_q, retry_d;
  div_codes_t        div_q, div_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              pll_reset_q, pll_reset_d;
  logic              locked_q, locked_d;
  logic              fail_q, fail_d;
  logic              bad_mode_q, bad_mode_d;
  logic              ready_q, ready_d;
  logic              load;

  logic              lock_s;
  logic [MODE_W-1:0] req;
  logic              accept;
  logic              req_bad;
  logic              req_same;

  lock_sync u_lock_sync (
    .clk   (clkin),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign req      = bus.mode_req;
  assign accept   = ready_q && bus.mode_req_valid;
  assign req_bad  = 32'(req) >= NUM_MODES;
  assign req_same = (req == mode_q);

  // State and registered outputs.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      rst_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      stb_cnt_q   <= '0;
      retry_q     <= '0;
      div_q       <= DIV_DEFAULT;
      mode_q      <= MODE_RESET;
      pll_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      bad_mode_q  <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      retry_q     <= retry_d;
      div_q       <= div_d;
      mode_q      <= mode_d;
      pll_reset_q <= pll_reset_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      bad_mode_q  <= bad_mode_d;
      ready_q     <= ready_d;
    end
  end

  // Sequencing, request handling and next-state output decode.
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    stb_cnt_d  = stb_cnt_q;
    retry_d    = retry_q;
    div_d      = div_q;
    mode_d     = mode_q;
    bad_mode_d = 1'b0;
    load       = 1'b0;

    case (state_q)
      ST_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = ST_WAIT_LOCK;
          rst_cnt_d = '0;
          tmo_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d   = ST_QUALIFY;
          stb_cnt_d = '0;
        end else if (tmo_cnt_q >= TMO_LAST) begin
          if (32'(retry_q) < MAX_RETRY) begin
            retry_d   = (retry_q == 2'd3) ? retry_q : retry_q + 2'd1;
            state_d   = ST_RESET;
            rst_cnt_d = '0;
          end else begin
            state_d = ST_FAIL;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_QUALIFY: begin
        // Timeout keeps counting across lock glitches; it only fires from WAIT_LOCK.
        if (tmo_cnt_q != TMO_LAST) begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
        if (!lock_s) begin
          state_d   = ST_WAIT_LOCK;
          stb_cnt_d = '0;
        end else if (stb_cnt_q == STB_LAST) begin
          state_d = ST_RUN;
        end else begin
          stb_cnt_d = stb_cnt_q + STB_W'(1);
        end
      end
      ST_RUN: begin
        // A new request takes priority over a simultaneous lock loss.
        if (accept && !req_bad && !req_same) begin
          load = 1'b1;
        end else if (!lock_s) begin
          state_d   = ST_RESET;
          rst_cnt_d = '0;
          retry_d   = '0;
        end
      end
      ST_FAIL: begin
        if (accept && !req_bad) begin
          load = 1'b1;
        end
      end
      default: begin
        state_d   = ST_RESET;
        rst_cnt_d = '0;
      end
    endcase

    if (load) begin
      mode_d    = req;
      div_d     = div_lookup(32'(req));
      retry_d   = '0;
      state_d   = ST_RESET;
      rst_cnt_d = '0;
    end

    if (accept && req_bad) begin
      bad_mode_d = 1'b1;
    end

    pll_reset_d = (state_d == ST_RESET) || (state_d == ST_FAIL);
    locked_d    = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
    ready_d     = (state_d == ST_RUN) || (state_d == ST_FAIL);
  end

  assign pll_reset          = pll_reset_q;
  assign pll_idsel          = div_q.idsel;
  assign pll_fbdsel         = div_q.fbdsel;
  assign pll_odsel          = div_q.odsel;
  assign mode_cur           = mode_q;
  assign locked             = locked_q;
  assign fail               = fail_q;
  assign retry_cnt          = retry_q;
  assign bus.mode_req_ready = ready_q;
  assign bus.bad_mode       = bad_mode_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Directed bench for pll_dyn_ctrl: reset-pulse scoreboard plus lock/retry/request checks.
module tb_pll_dyn_ctrl;

  localparam int unsigned NUM_MODES = 3;
  localparam int unsigned MW        = 2;

  localparam logic [17:0] E0 = {6'd61, 6'd50, 6'd62};
  localparam logic [17:0] E1 = {6'd60, 6'd53, 6'd60};
  localparam logic [17:0] E2 = {6'd62, 6'd53, 6'd62};

  typedef struct {
    int          len;   // 0 = length not checked
    logic [17:0] div;
    logic [1:0]  mode;
  } pulse_t;

  logic          clkin = 1'b0;
  logic          rst_n;
  logic          pll_lock;
  logic          pll_reset;
  logic [5:0]    pll_idsel, pll_fbdsel, pll_odsel;
  logic [MW-1:0] mode_cur;
  logic          locked, fail;
  logic [1:0]    retry_cnt;

  pll_dyn_if #(.MODE_W(MW)) bus ();

  pll_dyn_ctrl #(
    .NUM_MODES    (NUM_MODES),
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (20),
    .LOCK_STABLE  (8),
    .MAX_RETRY    (2)
  ) dut (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .bus        (bus),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .pll_idsel  (pll_idsel),
    .pll_fbdsel (pll_fbdsel),
    .pll_odsel  (pll_odsel),
    .mode_cur   (mode_cur),
    .locked     (locked),
    .fail       (fail),
    .retry_cnt  (retry_cnt)
  );

  always #5 clkin = ~clkin;

  int          n_checks = 0;
  int          n_pass   = 0;
  pulse_t      exp_q[$];
  int          hi_len   = 0;
  logic        prev_rst = 1'b1;
  logic [17:0] prev_div = E0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic push_pulse(input int len, input logic [17:0] div, input logic [1:0] mode);
    pulse_t p;
    p.len  = len;
    p.div  = div;
    p.mode = mode;
    exp_q.push_back(p);
  endtask

  // Advance to the next falling edge and score any reset pulse that just ended.
  task automatic step();
    logic [17:0] cur_div;
    pulse_t      e;
    logic        have;
    @(negedge clkin);
    cur_div = {pll_idsel, pll_fbdsel, pll_odsel};
    if (!rst_n) begin
      hi_len = 0;
    end else begin
      if (cur_div !== prev_div) chk("div_change_needs_reset", 32'(pll_reset), 32'(1));
      if (pll_reset) begin
        hi_len++;
      end else if (prev_rst) begin
        have = (exp_q.size() != 0);
        chk("pulse_expected", 32'(have), 32'(1));
        if (have) begin
          e = exp_q.pop_front();
          if (e.len != 0) chk("pulse_len", 32'(hi_len), 32'(e.len));
          chk("pulse_div", 32'(cur_div), 32'(e.div));
          chk("pulse_mode", 32'(mode_cur), 32'(e.mode));
        end
        hi_len = 0;
      end
    end
    prev_rst = pll_reset;
    prev_div = cur_div;
  endtask

  task automatic wait_rst(input logic lvl, input int bound, input string tag);
    int n = 0;
    while (pll_reset !== lvl && n < bound) begin
      step();
      n++;
    end
    chk(tag, 32'(pll_reset), 32'(lvl));
  endtask

  // pll_lock was raised at the current falling edge; locked must rise on the k-th edge after.
  task automatic expect_locked_after(input int k, input string tag);
    for (int i = 0; i < k - 1; i++) step();
    chk({tag, "_early"}, 32'(locked), 32'(0));
    step();
    chk({tag, "_rise"}, 32'(locked), 32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n              = 1'b0;
    pll_lock           = 1'b0;
    bus.mode_req       = '0;
    bus.mode_req_valid = 1'b0;
    repeat (3) step();

    // Reset values
    chk("rst_pll_reset", 32'(pll_reset), 32'(1));
    chk("rst_idsel", 32'(pll_idsel), 32'(61));
    chk("rst_fbdsel", 32'(pll_fbdsel), 32'(50));
    chk("rst_odsel", 32'(pll_odsel), 32'(62));
    chk("rst_mode_cur", 32'(mode_cur), 32'(0));
    chk("rst_locked", 32'(locked), 32'(0));
    chk("rst_fail", 32'(fail), 32'(0));
    chk("rst_bad_mode", 32'(bus.bad_mode), 32'(0));
    chk("rst_ready", 32'(bus.mode_req_ready), 32'(0));
    chk("rst_retry", 32'(retry_cnt), 32'(0));

    // Power-up: 4-cycle pulse, lock 5 cycles after release of pll_reset
    push_pulse(4, E0, 2'd0);
    @(posedge clkin);
    #1 rst_n = 1'b1;
    wait_rst(1'b0, 10, "pwr_rst_fall");
    repeat (5) step();
    pll_lock = 1'b1;
    expect_locked_after(11, "pwr_lock");
    chk("pwr_ready", 32'(bus.mode_req_ready), 32'(1));
    chk("pwr_retry", 32'(retry_cnt), 32'(0));

    // Lock loss in RUN: locked falls 3 cycles later, same mode reapplied
    pll_lock = 1'b0;
    push_pulse(4, E0, 2'd0);
    step();
    step();
    chk("loss_hold", 32'(locked), 32'(1));
    step();
    chk("loss_fall", 32'(locked), 32'(0));
    chk("loss_reset", 32'(pll_reset), 32'(1));
    wait_rst(1'b0, 10, "loss_rst_fall");

    // Glitchy lock: high 5, low 1, high again
    pll_lock = 1'b1;
    repeat (5) step();
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    expect_locked_after(11, "glitch_lock");

    // Request for the current mode is consumed without effect
    bus.mode_req       = 2'd0;
    bus.mode_req_valid = 1'b1;
    step();
    bus.mode_req_valid = 1'b0;
    chk("same_no_reset", 32'(pll_reset), 32'(0));
    chk("same_locked", 32'(locked), 32'(1));
    chk("same_bad_mode", 32'(bus.bad_mode), 32'(0));

    // Mode switch with simultaneous lock loss: request wins
    chk("sw_ready", 32'(bus.mode_req_ready), 32'(1));
    bus.mode_req       = 2'd2;
    bus.mode_req_valid = 1'b1;
    pll_lock           = 1'b0;
    push_pulse(4, E2, 2'd2);
    step();
    bus.mode_req_valid = 1'b0;
    chk("sw_reset_rise", 32'(pll_reset), 32'(1));
    chk("sw_locked_drop", 32'(locked), 32'(0));
    chk("sw_mode_cur", 32'(mode_cur), 32'(2));
    chk("sw_idsel", 32'(pll_idsel), 32'(62));
    chk("sw_fbdsel", 32'(pll_fbdsel), 32'(53));
    chk("sw_odsel", 32'(pll_odsel), 32'(62));
    wait_rst(1'b0, 10, "sw_rst_fall");
    pll_lock = 1'b1;
    expect_locked_after(11, "sw_lock");

    // Out-of-range request
    bus.mode_req       = 2'd3;
    bus.mode_req_valid = 1'b1;
    step();
    bus.mode_req_valid = 1'b0;
    chk("bad_pulse", 32'(bus.bad_mode), 32'(1));
    chk("bad_mode_cur", 32'(mode_cur), 32'(2));
    chk("bad_locked", 32'(locked), 32'(1));
    chk("bad_no_reset", 32'(pll_reset), 32'(0));
    step();
    chk("bad_pulse_end", 32'(bus.bad_mode), 32'(0));
    chk("bad_locked_after", 32'(locked), 32'(1));

    // Timeout: loss pulse, two retries, then FAIL
    pll_lock = 1'b0;
    push_pulse(4, E2, 2'd2);
    push_pulse(4, E2, 2'd2);
    push_pulse(4, E2, 2'd2);
    wait_rst(1'b1, 5, "to_loss_rise");
    wait_rst(1'b0, 10, "to_loss_fall");
    chk("to_retry0", 32'(retry_cnt), 32'(0));
    wait_rst(1'b1, 30, "to_r1_rise");
    wait_rst(1'b0, 10, "to_r1_fall");
    chk("to_retry1", 32'(retry_cnt), 32'(1));
    wait_rst(1'b1, 30, "to_r2_rise");
    wait_rst(1'b0, 10, "to_r2_fall");
    chk("to_retry2", 32'(retry_cnt), 32'(2));
    n = 0;
    while (fail !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk("to_fail", 32'(fail), 32'(1));
    chk("to_fail_reset", 32'(pll_reset), 32'(1));
    chk("to_fail_retry", 32'(retry_cnt), 32'(2));
    chk("to_fail_ready", 32'(bus.mode_req_ready), 32'(1));
    chk("to_fail_locked", 32'(locked), 32'(0));

    // Recover from FAIL with mode 1
    push_pulse(0, E1, 2'd1);
    bus.mode_req       = 2'd1;
    bus.mode_req_valid = 1'b1;
    step();
    bus.mode_req_valid = 1'b0;
    chk("rec_fail_clear", 32'(fail), 32'(0));
    chk("rec_retry", 32'(retry_cnt), 32'(0));
    chk("rec_mode_cur", 32'(mode_cur), 32'(1));
    chk("rec_idsel", 32'(pll_idsel), 32'(60));
    chk("rec_fbdsel", 32'(pll_fbdsel), 32'(53));
    chk("rec_odsel", 32'(pll_odsel), 32'(60));
    chk("rec_reset", 32'(pll_reset), 32'(1));
    chk("rec_ready", 32'(bus.mode_req_ready), 32'(0));
    wait_rst(1'b0, 10, "rec_rst_fall");
    pll_lock = 1'b1;
    expect_locked_after(11, "rec_lock");

    chk("sb_empty", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
